bus_master_6502: RTL and testbench

BUS_MASTER_6502 -- requirements
Module: bus_master_6502

---
 rtl/bus_master_6502.sv | 179 +++++++++++++++++
 tb/tb_bus_master_6502.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_6502.sv
// bus_master_6502 -- turns single host requests into 6502-style bus cycles.
//
// A request accepted in IDLE runs PHI1 (address setup, phi2 low), then PHI2
// (phi2 high, stretched while bus_rdy is low), then a single END cycle that
// keeps address/R/W (and write data) on the bus for hold time and pulses
// rsp_valid. If bus_rdy stays low for MAX_WAIT extension cycles, the cycle
// ends with rsp_err set and read data forced to 0x00.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       host request handshake (ready only in IDLE)
//   req_rw/req_addr/req_wdata request fields (rw: 1=read, 0=write)
//   rsp_valid                 one-cycle completion pulse
//   rsp_rdata/rsp_err         read data / timeout flag, held until next END
//   bus_addr/bus_rw/bus_phi2  6502 address, R/W and phase-2 strobe
//   bus_dout/bus_doe          write data and its output enable
//   bus_din/bus_rdy           read data and target ready from the bus
// Every output is a flop; no input reaches an output combinationally.

module bus_master_6502 #(
   parameter int unsigned PHI1_CYCLES = 2,
   parameter int unsigned PHI2_CYCLES = 2,
   parameter int unsigned MAX_WAIT    = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rw,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic [15:0] bus_addr,
   output logic        bus_rw,
   output logic        bus_phi2,
   output logic [7:0]  bus_dout,
   output logic        bus_doe,
   input  logic [7:0]  bus_din,
   input  logic        bus_rdy
);

   typedef enum logic [1:0] {StIdle, StPhi1, StPhi2, StEnd} state_e;

   localparam logic [3:0] Phi1Last = 4'(PHI1_CYCLES - 1);
   localparam logic [3:0] Phi2Last = 4'(PHI2_CYCLES - 1);
   localparam logic [7:0] WaitMax  = 8'(MAX_WAIT);

   state_e      state_q, state_d;
   logic [3:0]  phase_q, phase_d;
   logic [7:0]  wait_q, wait_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic [15:0] bus_addr_q, bus_addr_d;
   logic        bus_rw_q, bus_rw_d;
   logic        bus_phi2_q, bus_phi2_d;
   logic [7:0]  bus_dout_q, bus_dout_d;
   logic        bus_doe_q, bus_doe_d;

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      wait_d      = wait_q;
      wdata_d     = wdata_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      bus_addr_d  = bus_addr_q;
      bus_rw_d    = bus_rw_q;
      bus_phi2_d  = bus_phi2_q;
      bus_dout_d  = bus_dout_q;
      bus_doe_d   = bus_doe_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d     = StPhi1;
               phase_d     = '0;
               wait_d      = '0;
               wdata_d     = req_wdata;
               bus_addr_d  = req_addr;
               bus_rw_d    = req_rw;
               req_ready_d = 1'b0;
            end
         end
         StPhi1: begin
            if (phase_q == Phi1Last) begin
               state_d    = StPhi2;
               phase_d    = '0;
               bus_phi2_d = 1'b1;
               if (!bus_rw_q) begin
                  bus_doe_d  = 1'b1;
                  bus_dout_d = wdata_q;
               end
            end else begin
               phase_d = phase_q + 4'd1;
            end
         end
         StPhi2: begin
            if (phase_q != Phi2Last) begin
               phase_d = phase_q + 4'd1;
            end else if (bus_rdy) begin
               // bus_rw_q still holds the latched direction here
               state_d     = StEnd;
               bus_phi2_d  = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = bus_rw_q ? bus_din : 8'h00;
            end else if (wait_q == WaitMax) begin
               state_d     = StEnd;
               bus_phi2_d  = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = 8'h00;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         StEnd: begin
            // address held; R/W returns to read and data bus released
            state_d     = StIdle;
            req_ready_d = 1'b1;
            bus_rw_d    = 1'b1;
            bus_doe_d   = 1'b0;
            phase_d     = '0;
            wait_d      = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         phase_q     <= '0;
         wait_q      <= '0;
         wdata_q     <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         bus_addr_q  <= '0;
         bus_rw_q    <= 1'b1;
         bus_phi2_q  <= 1'b0;
         bus_dout_q  <= '0;
         bus_doe_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         wait_q      <= wait_d;
         wdata_q     <= wdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         bus_addr_q  <= bus_addr_d;
         bus_rw_q    <= bus_rw_d;
         bus_phi2_q  <= bus_phi2_d;
         bus_dout_q  <= bus_dout_d;
         bus_doe_q   <= bus_doe_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign bus_addr  = bus_addr_q;
   assign bus_rw    = bus_rw_q;
   assign bus_phi2  = bus_phi2_q;
   assign bus_dout  = bus_dout_q;
   assign bus_doe   = bus_doe_q;

endmodule

// File: tb/tb_bus_master_6502.sv
// tb_bus_master_6502 -- self-checking bench for bus_master_6502.
// A transaction-level model (cycles elapsed since acceptance plus count of
// low bus_rdy samples) predicts every output each cycle; directed traces pin
// the model with hand-computed cycle numbers, then random traffic follows.

module tb_bus_master_6502;

   localparam int unsigned P1 = 2;
   localparam int unsigned P2 = 2;
   localparam int unsigned MW = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_rw;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic [15:0] bus_addr;
   logic        bus_rw;
   logic        bus_phi2;
   logic [7:0]  bus_dout;
   logic        bus_doe;
   logic [7:0]  bus_din;
   logic        bus_rdy;

   bus_master_6502 #(
      .PHI1_CYCLES(P1),
      .PHI2_CYCLES(P2),
      .MAX_WAIT   (MW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_rw   (req_rw),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .bus_addr (bus_addr),
      .bus_rw   (bus_rw),
      .bus_phi2 (bus_phi2),
      .bus_dout (bus_dout),
      .bus_doe  (bus_doe),
      .bus_din  (bus_din),
      .bus_rdy  (bus_rdy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_t = cycles since acceptance (0 = idle), frozen while PHI2 is
   // stretched; m_z = low bus_rdy samples so far; m_end = completion cycle.
   int          m_t = 0;
   int          m_z = 0;
   bit          m_end = 1'b0;
   bit          m_rw = 1'b1;
   logic [15:0] m_addr = '0;
   logic [7:0]  m_wdata = '0;
   logic [7:0]  m_rdata = '0;
   bit          m_err = 1'b0;

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_t = 0; m_z = 0; m_end = 1'b0; m_rw = 1'b1;
         m_addr = '0; m_rdata = '0; m_err = 1'b0;
      end else if (m_t == 0) begin
         if (req_valid) begin
            m_t = 1; m_z = 0; m_rw = req_rw; m_addr = req_addr; m_wdata = req_wdata;
         end
      end else if (m_end) begin
         m_t = 0; m_end = 1'b0;
      end else if (m_t >= int'(P1 + P2)) begin
         if (bus_rdy) begin
            m_end = 1'b1; m_err = 1'b0; m_rdata = m_rw ? bus_din : 8'h00;
         end else if (m_z == int'(MW)) begin
            m_end = 1'b1; m_err = 1'b1; m_rdata = 8'h00;
         end else begin
            m_z++;
         end
      end else begin
         m_t++;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", 32'(req_ready), 32'(m_t == 0));
         chk("bus_phi2", 32'(bus_phi2), 32'(m_t > int'(P1) && !m_end));
         chk("bus_rw", 32'(bus_rw), 32'((m_t == 0) ? 1'b1 : m_rw));
         chk("bus_doe", 32'(bus_doe), 32'(m_t > int'(P1) && !m_rw));
         if (m_t > int'(P1) && !m_rw) chk("bus_dout", 32'(bus_dout), 32'(m_wdata));
         chk("bus_addr", 32'(bus_addr), 32'(m_addr));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_end));
         chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
         chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end
   end

   // Per-cycle trace of one directed transaction; index n = cycle n after
   // the acceptance edge.
   logic       tr_phi2 [0:31];
   logic       tr_rsp  [0:31];
   logic       tr_rw   [0:31];
   logic       tr_doe  [0:31];
   logic       tr_rdy_o[0:31];
   logic       tr_err  [0:31];
   logic [7:0] tr_dout [0:31];
   logic [7:0] tr_rdata[0:31];

   task automatic trace(input bit rw, input logic [15:0] addr, input logic [7:0] wd,
                        input logic [7:0] din, input int nz, input int ncyc,
                        input bit keep, input int rst_at);
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
      bus_din = din; bus_rdy = 1'b1; rst = 1'b0;
      @(posedge clk);
      for (int n = 1; n <= ncyc; n++) begin
         #1;
         if (!keep) req_valid = 1'b0;
         bus_rdy = (n >= 4 && n < 4 + nz) ? 1'b0 : 1'b1;
         rst = (n == rst_at);
         @(negedge clk);
         tr_phi2[n] = bus_phi2; tr_rsp[n] = rsp_valid; tr_rw[n] = bus_rw;
         tr_doe[n] = bus_doe; tr_rdy_o[n] = req_ready; tr_err[n] = rsp_err;
         tr_dout[n] = bus_dout; tr_rdata[n] = rsp_rdata;
         @(posedge clk);
      end
      #1;
      req_valid = 1'b0; rst = 1'b0; bus_rdy = 1'b1;
   endtask

   int cnt;
   int low_run;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_rw = 1'b1; req_addr = '0; req_wdata = '0;
      bus_din = '0; bus_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      @(negedge clk);
      chk("rst req_ready", 32'(req_ready), 32'd1);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst rsp_rdata", 32'(rsp_rdata), 32'h00);
      chk("rst rsp_err", 32'(rsp_err), 32'd0);
      chk("rst bus_addr", 32'(bus_addr), 32'h0000);
      chk("rst bus_rw", 32'(bus_rw), 32'd1);
      chk("rst bus_phi2", 32'(bus_phi2), 32'd0);
      chk("rst bus_dout", 32'(bus_dout), 32'h00);
      chk("rst bus_doe", 32'(bus_doe), 32'd0);
      rst = 1'b0;

      // Zero-wait read
      trace(1'b1, 16'hC000, 8'h00, 8'h5A, 0, 6, 1'b0, 0);
      chk("rd phi2 c2", 32'(tr_phi2[2]), 32'd0);
      chk("rd phi2 c3", 32'(tr_phi2[3]), 32'd1);
      chk("rd phi2 c4", 32'(tr_phi2[4]), 32'd1);
      chk("rd phi2 c5", 32'(tr_phi2[5]), 32'd0);
      chk("rd rsp c4", 32'(tr_rsp[4]), 32'd0);
      chk("rd rsp c5", 32'(tr_rsp[5]), 32'd1);
      chk("rd rdata", 32'(tr_rdata[5]), 32'h5A);
      chk("rd err", 32'(tr_err[5]), 32'd0);
      chk("rd ready c6", 32'(tr_rdy_o[6]), 32'd1);

      // Zero-wait write
      trace(1'b0, 16'h8003, 8'hA5, 8'h33, 0, 6, 1'b0, 0);
      for (int n = 1; n <= 5; n++) chk("wr rw low", 32'(tr_rw[n]), 32'd0);
      chk("wr rw c6", 32'(tr_rw[6]), 32'd1);
      chk("wr doe c2", 32'(tr_doe[2]), 32'd0);
      for (int n = 3; n <= 5; n++) begin
         chk("wr doe", 32'(tr_doe[n]), 32'd1);
         chk("wr dout", 32'(tr_dout[n]), 32'hA5);
      end
      chk("wr rsp c5", 32'(tr_rsp[5]), 32'd1);
      chk("wr rdata", 32'(tr_rdata[5]), 32'h00);

      // Read stretched by three low bus_rdy samples
      trace(1'b1, 16'h1234, 8'h00, 8'h77, 3, 9, 1'b0, 0);
      cnt = 0;
      for (int n = 1; n <= 9; n++) if (tr_phi2[n]) cnt++;
      chk("ext phi2 count", 32'(cnt), 32'd5);
      chk("ext phi2 c7", 32'(tr_phi2[7]), 32'd1);
      chk("ext phi2 c8", 32'(tr_phi2[8]), 32'd0);
      chk("ext rsp c7", 32'(tr_rsp[7]), 32'd0);
      chk("ext rsp c8", 32'(tr_rsp[8]), 32'd1);
      chk("ext rdata", 32'(tr_rdata[8]), 32'h77);

      // Timeout: bus_rdy held low
      trace(1'b1, 16'h2000, 8'h00, 8'hEE, 100, 22, 1'b0, 0);
      cnt = 0;
      for (int n = 1; n <= 22; n++) if (tr_phi2[n]) cnt++;
      chk("to phi2 count", 32'(cnt), 32'd17);
      chk("to rsp c20", 32'(tr_rsp[20]), 32'd1);
      chk("to err", 32'(tr_err[20]), 32'd1);
      chk("to rdata", 32'(tr_rdata[20]), 32'h00);
      chk("to ready c21", 32'(tr_rdy_o[21]), 32'd1);

      // Reset during cycle 4 of a write
      trace(1'b0, 16'h4000, 8'h3C, 8'h00, 0, 8, 1'b0, 4);
      chk("rw phi2 c4", 32'(tr_phi2[4]), 32'd1);
      chk("rw phi2 c5", 32'(tr_phi2[5]), 32'd0);
      chk("rw doe c5", 32'(tr_doe[5]), 32'd0);
      chk("rw rw c5", 32'(tr_rw[5]), 32'd1);
      chk("rw ready c5", 32'(tr_rdy_o[5]), 32'd1);
      cnt = 0;
      for (int n = 1; n <= 8; n++) if (tr_rsp[n]) cnt++;
      chk("rw no rsp", 32'(cnt), 32'd0);

      // Back-to-back reads with req_valid held
      trace(1'b1, 16'h0200, 8'h00, 8'h5A, 0, 11, 1'b1, 0);
      chk("b2b rsp c5", 32'(tr_rsp[5]), 32'd1);
      chk("b2b ready c6", 32'(tr_rdy_o[6]), 32'd1);
      chk("b2b phi2 c6", 32'(tr_phi2[6]), 32'd0);
      chk("b2b rw c6", 32'(tr_rw[6]), 32'd1);
      chk("b2b ready c7", 32'(tr_rdy_o[7]), 32'd0);
      chk("b2b rsp c10", 32'(tr_rsp[10]), 32'd0);
      chk("b2b rsp c11", 32'(tr_rsp[11]), 32'd1);

      // Random traffic, occasional long bus_rdy stalls and resets
      low_run = 0;
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk);
         #1;
         req_valid = 1'($urandom_range(0, 1));
         req_rw    = 1'($urandom_range(0, 1));
         req_addr  = 16'($urandom);
         req_wdata = 8'($urandom);
         bus_din   = 8'($urandom);
         if (low_run > 0) begin
            bus_rdy = 1'b0;
            low_run--;
         end else begin
            bus_rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 60) == 0) low_run = 20;
         end
         rst = ($urandom_range(0, 150) == 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0; req_valid = 1'b0; bus_rdy = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
